// File: rtl/sine_stream_ctrl.sv
// Streams a sine table out of a 3-port sample ROM as L=3 parallel blocks to a FIR,
// with a valid/ready handshake, optional looping and a synchronous stop.
module sine_stream_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data_1,
  input  logic [DATA_WIDTH-1:0] rom_data_2,
  input  logic [DATA_WIDTH-1:0] rom_data_3,
  output logic [DATA_WIDTH-1:0] x0,
  output logic [DATA_WIDTH-1:0] x1,
  output logic [DATA_WIDTH-1:0] x2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] block_count
);

  localparam int NBLK = (2 ** ADDR_WIDTH) / 3;
  localparam logic [ADDR_WIDTH-1:0] LAST_BASE = ADDR_WIDTH'(3 * (NBLK - 1));

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   rom_addr_n, block_count_n, next_base;
  logic [DATA_WIDTH-1:0]   x0_n, x1_n, x2_n;
  logic                    out_valid_n;

  // rom_addr always points one block ahead of x0..x2, so in STREAM it reads 0
  // exactly when the block on the outputs is the one at LAST_BASE.
  assign next_base = (rom_addr == LAST_BASE) ? '0 : rom_addr + ADDR_WIDTH'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rom_addr    <= '0;
      x0          <= '0;
      x1          <= '0;
      x2          <= '0;
      out_valid   <= 1'b0;
      block_count <= '0;
    end else begin
      state       <= state_n;
      rom_addr    <= rom_addr_n;
      x0          <= x0_n;
      x1          <= x1_n;
      x2          <= x2_n;
      out_valid   <= out_valid_n;
      block_count <= block_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    rom_addr_n    = rom_addr;
    x0_n          = x0;
    x1_n          = x1;
    x2_n          = x2;
    out_valid_n   = out_valid;
    block_count_n = block_count;
    if (stop) begin
      state_n     = IDLE;
      out_valid_n = 1'b0;
      rom_addr_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n       = LOAD;
            rom_addr_n    = '0;
            block_count_n = '0;
          end
        end
        LOAD: begin
          x0_n        = rom_data_1;
          x1_n        = rom_data_2;
          x2_n        = rom_data_3;
          out_valid_n = 1'b1;
          rom_addr_n  = next_base;
          state_n     = STREAM;
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            block_count_n = block_count + ADDR_WIDTH'(1);
            if (rom_addr == '0 && !loop_en) begin
              out_valid_n = 1'b0;
              state_n     = DONE;
            end else begin
              x0_n       = rom_data_1;
              x1_n       = rom_data_2;
              x2_n       = rom_data_3;
              rom_addr_n = next_base;
            end
          end
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == STREAM);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sine_stream_ctrl.sv
// Directed bench for sine_stream_ctrl: full stream, random stalls, looping with
// count wrap, stop during stall, async reset and start held through DONE.
module tb_sine_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en, out_ready;
  logic [8:0]  rom_addr, block_count;
  logic [15:0] rom_data_1, rom_data_2, rom_data_3, x0, x1, x2;
  logic        out_valid, busy, done;

  int checks = 0;
  int errors = 0;
  int k, cyc, r;

  sine_stream_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data_1(rom_data_1), .rom_data_2(rom_data_2),
    .rom_data_3(rom_data_3), .x0(x0), .x1(x1), .x2(x2), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .block_count(block_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input int a);
    return 16'((a * 40503 + 12345) ^ (a << 3));
  endfunction

  assign rom_data_1 = rom_word(int'(rom_addr));
  assign rom_data_2 = rom_word(int'(rom_addr) + 1);
  assign rom_data_3 = rom_word(int'(rom_addr) + 2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic s, input logic p, input logic rdy, input logic lp);
    start     = s;
    stop      = p;
    out_ready = rdy;
    loop_en   = lp;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_block(input string tag, input int base);
    check_output({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_output({tag, ".x0"}, 32'(x0), 32'(rom_word(base)));
    check_output({tag, ".x1"}, 32'(x1), 32'(rom_word(base + 1)));
    check_output({tag, ".x2"}, 32'(x2), 32'(rom_word(base + 2)));
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, ".addr"}, 32'(rom_addr), 32'd0);
    check_output({tag, ".x0"}, 32'(x0), 32'd0);
    check_output({tag, ".x1"}, 32'(x1), 32'd0);
    check_output({tag, ".x2"}, 32'(x2), 32'd0);
    check_output({tag, ".valid"}, 32'(out_valid), 32'd0);
    check_output({tag, ".busy"}, 32'(busy), 32'd0);
    check_output({tag, ".done"}, 32'(done), 32'd0);
    check_output({tag, ".count"}, 32'(block_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    #12;
    check_all_zero("reset");
    tick();
    rst = 1'b0;

    // Full non-looping stream with out_ready held high
    $display("[TB] full stream");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("load.busy", 32'(busy), 32'd1);
    check_output("load.valid", 32'(out_valid), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("first.addr", 32'(rom_addr), 32'd3);
    for (int i = 0; i < 170; i++) begin
      check_block("full", 3 * i);
      check_output("full.count", 32'(block_count), 32'(i));
      check_output("full.done", 32'(done), 32'd0);
      tick();
    end
    check_output("full.done_pulse", 32'(done), 32'd1);
    check_output("full.end_valid", 32'(out_valid), 32'd0);
    check_output("full.end_busy", 32'(busy), 32'd0);
    check_output("full.end_count", 32'(block_count), 32'd170);
    tick();
    check_output("full.done_clear", 32'(done), 32'd0);
    check_output("full.idle_busy", 32'(busy), 32'd0);

    // Random stalls: same sequence, no loss or duplication
    $display("[TB] random stalls");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    tick();
    k = 0;
    cyc = 0;
    while (k < 170 && cyc < 3000) begin
      check_block("stall", 3 * k);
      check_output("stall.count", 32'(block_count), 32'(k));
      r = $urandom_range(0, 1);
      out_ready = r[0];
      tick();
      if (r[0]) k++;
      cyc++;
    end
    check_output("stall.finished", 32'(k), 32'd170);
    check_output("stall.done", 32'(done), 32'd1);
    check_output("stall.end_count", 32'(block_count), 32'd170);
    tick();

    // Looping: wrap 507 -> 0 without a bubble, count wraps 511 -> 0
    $display("[TB] looping");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 515; i++) begin
      check_block("loop", 3 * (i % 170));
      check_output("loop.count", 32'(block_count), 32'(i % 512));
      loop_en = ((i % 170) == 169) ? 1'b1 : 1'(i % 2);
      tick();
    end
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    check_output("loopstop.valid", 32'(out_valid), 32'd0);
    check_output("loopstop.busy", 32'(busy), 32'd0);
    check_output("loopstop.done", 32'(done), 32'd0);
    check_output("loopstop.addr", 32'(rom_addr), 32'd0);
    check_output("loopstop.count", 32'(block_count), 32'd3);
    check_output("loopstop.x0", 32'(x0), 32'(rom_word(15)));

    // Stop while stalled on base 120, then restart from base 0
    $display("[TB] stop during stall");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) tick();
    out_ready = 1'b0;
    tick();
    tick();
    check_block("hold120", 120);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_output("stop.valid", 32'(out_valid), 32'd0);
    check_output("stop.done", 32'(done), 32'd0);
    check_output("stop.busy", 32'(busy), 32'd0);
    check_output("stop.count", 32'(block_count), 32'd40);
    check_output("stop.x0", 32'(x0), 32'(rom_word(120)));
    tick();
    check_output("stop.idle_valid", 32'(out_valid), 32'd0);
    check_output("stop.idle_done", 32'(done), 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    tick();
    check_block("restart", 0);
    check_output("restart.count", 32'(block_count), 32'd0);
    check_output("restart.addr", 32'(rom_addr), 32'd3);

    // Asynchronous reset mid-stream
    $display("[TB] async reset");
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    start = 1'b1;
    tick();
    tick();
    check_output("rst.start_busy", 32'(busy), 32'd0);
    check_output("rst.start_valid", 32'(out_valid), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check_output("post_rst.busy", 32'(busy), 32'd0);
    check_output("post_rst.valid", 32'(out_valid), 32'd0);

    // start held high through DONE starts a fresh stream from IDLE
    $display("[TB] start held through done");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 170; i++) tick();
    check_output("held.done", 32'(done), 32'd1);
    check_output("held.count", 32'(block_count), 32'd170);
    tick();
    check_output("held.done_once", 32'(done), 32'd0);
    check_output("held.idle_busy", 32'(busy), 32'd0);
    tick();
    check_output("held.reload_busy", 32'(busy), 32'd1);
    check_output("held.count_clr", 32'(block_count), 32'd0);
    tick();
    check_block("held.first", 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sine_stream_ctrl.md
SINE_STREAM_CTRL -- requirements
Module: sine_stream_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, sample ROM address width.
REQ-002 Parameter DATA_WIDTH, default 16, sample width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a stream; sampled only in IDLE.
REQ-006 stop  input  1  synchronous abort; wins over every other input.
REQ-007 loop_en  input  1  1 = wrap to address 0 after the last block; 0 = finish.
REQ-008 rom_addr  output  ADDR_WIDTH  base address to the 3-port sample ROM (ROM returns rom_addr, +1, +2 combinationally).
REQ-009 rom_data_1, rom_data_2, rom_data_3  input  DATA_WIDTH each  ROM samples at rom_addr, rom_addr+1, rom_addr+2.
REQ-010 x0, x1, x2  output  DATA_WIDTH each  registered L=3 parallel block to the FIR (x0 = oldest sample).
REQ-011 out_valid  output  1  x0..x2 hold a valid block.
REQ-012 out_ready  input  1  FIR accepts the block this cycle.
REQ-013 busy  output  1  high in LOAD and STREAM.
REQ-014 done  output  1  one-cycle pulse when a non-looping stream completes.
REQ-015 block_count  output  ADDR_WIDTH  blocks accepted since the last start, modulo 2^ADDR_WIDTH.

Function
REQ-016 Constants: NBLK = floor(2^ADDR_WIDTH / 3); LAST_BASE = 3*(NBLK-1) (170 and 507 at default); rom_addr never exceeds LAST_BASE.
REQ-017 States: IDLE, LOAD, STREAM, DONE; encoding free.
REQ-018 IDLE: start=1 -> LOAD, rom_addr <= 0, block_count <= 0; otherwise hold.
REQ-019 LOAD (one cycle): x0/x1/x2 <= rom_data_1/2/3, out_valid <= 1, rom_addr <= 3, -> STREAM.
REQ-020 Handshake: a block transfers on a cycle with out_valid=1 and out_ready=1; x0..x2 and out_valid are stable while out_valid=1 and out_ready=0.
REQ-021 STREAM on transfer when the block just accepted is not at LAST_BASE: capture rom_data_1..3 into x0..x2, rom_addr <= rom_addr+3, block_count <= block_count+1, out_valid stays 1.
REQ-022 Address wrap: the increment from LAST_BASE is to 0, never LAST_BASE+3.
REQ-023 STREAM on transfer of the LAST_BASE block with loop_en=1: capture block at rom_addr (=0 after wrap), continue; no bubble on out_valid.
REQ-024 STREAM on transfer of the LAST_BASE block with loop_en=0: out_valid <= 0, block_count incremented, -> DONE.
REQ-025 loop_en is sampled only at the LAST_BASE transfer; changes elsewhere have no effect.
REQ-026 DONE: done=1 for exactly this one cycle, -> IDLE; start ignored in DONE.
REQ-027 Zero-bubble throughput: with out_ready held 1, one block transfers per clock from the first out_valid cycle.
REQ-028 Latency: start sampled at edge E0 -> out_valid=1 after edge E1 with x = samples 0,1,2.
REQ-029 stop=1 in any state: next state IDLE, out_valid <= 0, done not asserted, rom_addr <= 0; x0..x2 and block_count hold.
REQ-030 busy = 1 exactly in LOAD and STREAM; done and out_valid never both 1.

Reset
REQ-031 rst=1 forces immediately, independent of clk: state IDLE, rom_addr 0, x0/x1/x2 0, out_valid 0, done 0, busy 0, block_count 0.
REQ-032 Reset asserted mid-stream discards the in-flight block; after release, no output activity until a new start.

Verification
REQ-033 Reset, start at cycle 0, out_ready=1, loop_en=0 -> 170 consecutive transfers, bases 0,3,...,507, x = rom[b], rom[b+1], rom[b+2]; done pulses once; block_count=170.
REQ-034 out_ready toggled pseudo-randomly -> no block lost or duplicated; x0..x2 constant while stalled; sequence identical to REQ-033.
REQ-035 loop_en=1 -> block after base 507 is base 0 on the next cycle, no out_valid gap; block_count wraps 511->0 without affecting data.
REQ-036 stop asserted during stall at base 120 -> next cycle IDLE, out_valid 0, no done; fresh start resumes at base 0.
REQ-037 rst asserted asynchronously between edges in STREAM -> all outputs 0 before the next edge; start ignored while rst=1.
REQ-038 start held high through DONE -> done high one cycle, then new stream begins from IDLE with block_count cleared.
